// File: rtl/next_pc_ctrl_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, next-PC
// source select and default vectors.
package next_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ILL  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ = 3'd0,
    SEL_BR  = 3'd1,
    SEL_J   = 3'd2,
    SEL_JR  = 3'd3,
    SEL_EXC = 3'd4
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEF_BOOT_CYCLES  = 4;

  // Signed word offset scaled to a byte offset.
  function automatic logic [31:0] word_off(
    input logic [15:0] off
  );
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch/jump target generation and
// register-jump alignment check.
module pc_target_calc
  import next_pc_ctrl_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [15:0] branch_off,
  input  logic [25:0] jump_addr,
  input  logic [1:0]  jr_lsb,
  output logic [31:0] br_target,
  output logic [31:0] j_target,
  output logic        jr_misaligned
);

  assign br_target     = pc_plus4 + word_off(branch_off);
  assign j_target      = {pc_plus4[31:28], jump_addr, 2'b00};
  assign jr_misaligned = |jr_lsb;

endmodule

// File: rtl/next_pc_ctrl.sv
// Program counter owner: boot delay, next-PC select, stall hold,
// halt/resume and misaligned register-jump trapping.
module next_pc_ctrl
  import next_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        redirect,
  output logic        exc,
  output logic [1:0]  state
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        exc_q, exc_d;

  pc_sel_e     sel;
  logic [31:0] sel_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        jr_mis;
  logic        advance;

  assign pc_plus4 = pc_q + 32'd4;
  assign advance  = imem_ready & ~stall;

  pc_target_calc u_tgt (
    .pc_plus4      (pc_plus4),
    .branch_off    (branch_off),
    .jump_addr     (jump_addr),
    .jr_lsb        (jr_target[1:0]),
    .br_target     (br_target),
    .j_target      (j_target),
    .jr_misaligned (jr_mis)
  );

  // Priority: jr > jump > branch > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (jr) begin
      sel = jr_mis ? SEL_EXC : SEL_JR;
    end else if (jump) begin
      sel = SEL_J;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    sel_pc = pc_plus4;
    case (sel)
      SEL_BR:  sel_pc = br_target;
      SEL_J:   sel_pc = j_target;
      SEL_JR:  sel_pc = jr_target;
      SEL_EXC: sel_pc = EXC_VECTOR;
      default: sel_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    exc_d      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (advance) begin
          pc_d       = sel_pc;
          redirect_d = (sel != SEL_SEQ);
          exc_d      = (sel == SEL_EXC);
          if (halt) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      cnt_q      <= 8'd0;
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      exc_q      <= exc_d;
    end
  end

  assign pc       = pc_q;
  assign imem_req = (state_q == ST_RUN);
  assign redirect = redirect_q;
  assign exc      = exc_q;
  assign state    = state_q;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Bench for next_pc_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_next_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0080;
  localparam int          BC = 4;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready, branch_taken;
  logic [15:0] branch_off;
  logic        jump;
  logic [25:0] jump_addr;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt, resume;
  logic [31:0] pc, pc_plus4;
  logic        imem_req, redirect, exc;
  logic [1:0]  state;

  always #5 clk = ~clk;

  next_pc_ctrl #(
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .BOOT_CYCLES  (BC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jr           (jr),
    .jr_target    (jr_target),
    .halt         (halt),
    .resume       (resume),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_req     (imem_req),
    .redirect     (redirect),
    .exc          (exc),
    .state        (state)
  );

  int errs = 0;
  int checks = 0;

  logic [31:0] m_pc = RV;
  int          m_st = 0;
  int          m_cnt = 0;
  bit          m_red = 1'b0;
  bit          m_exc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    branch_taken = 1'b0; branch_off = 16'h0;
    jump = 1'b0; jump_addr = 26'h0;
    jr = 1'b0; jr_target = 32'h0;
    halt = 1'b0; resume = 1'b0;
  endtask

  // Predict one clock edge from the current inputs, clock, then compare.
  task automatic tick(input string tag);
    logic [31:0] npc;
    int          nst, ncnt, off;
    bit          nred, nexc;
    npc = m_pc; nst = m_st; ncnt = m_cnt; nred = 0; nexc = 0;
    if (rst) begin
      npc = RV; nst = 0; ncnt = 0;
    end else if (m_st == 0) begin
      if (m_cnt == BC - 1) nst = 1;
      else ncnt = m_cnt + 1;
    end else if (m_st == 2) begin
      if (resume) nst = 1;
    end else if (imem_ready && !stall) begin
      if (jr) begin
        nred = 1;
        if (jr_target % 4 != 0) begin
          npc = EV; nexc = 1;
        end else begin
          npc = jr_target;
        end
      end else if (jump) begin
        nred = 1;
        npc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_addr) << 2);
      end else if (branch_taken) begin
        nred = 1;
        off = int'($signed(branch_off));
        npc = m_pc + 32'd4 + 32'(off * 4);
      end else begin
        npc = m_pc + 32'd4;
      end
      if (halt) nst = 2;
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_st = nst; m_cnt = ncnt; m_red = nred; m_exc = nexc;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".st"}, 32'(state), 32'(m_st));
    chk({tag, ".req"}, 32'(imem_req), 32'(m_st == 1));
    chk({tag, ".red"}, 32'(redirect), 32'(m_red));
    chk({tag, ".exc"}, 32'(exc), 32'(m_exc));
  endtask

  task automatic go_to(input logic [31:0] a);
    clr(); jr = 1'b1; jr_target = a;
    tick("goto");
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick("rst");
    chk("rst_pc", pc, 32'h0);
    chk("rst_st", 32'(state), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    clr();
    for (int i = 0; i < BC - 1; i++) begin
      tick("boot");
      chk("boot_req", 32'(imem_req), 32'd0);
    end
    tick("boot_end");
    chk("run_st", 32'(state), 32'd1);
    chk("run_req", 32'(imem_req), 32'd1);
    chk("run_pc", pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick("seq");
      chk("seq_pc", pc, 32'(4 * (i + 1)));
    end

    go_to(32'h3000_0010);
    jump = 1'b1; jump_addr = 26'h0000040;
    tick("jmp");
    chk("jmp_pc", pc, 32'h3000_0100);
    chk("jmp_red", 32'(redirect), 32'd1);
    clr(); imem_ready = 1'b0;
    tick("jmp_idle");
    chk("jmp_red_clr", 32'(redirect), 32'd0);

    go_to(32'h100);
    branch_taken = 1'b1; branch_off = 16'hFFFC;
    tick("br");
    chk("br_pc", pc, 32'hF4);
    go_to(32'h100);
    branch_taken = 1'b1; branch_off = 16'hFFFC;
    jump = 1'b1; jump_addr = 26'h10;
    tick("br_j");
    chk("br_j_pc", pc, 32'h40);

    go_to(32'h202);
    chk("jr_mis_pc", pc, EV);
    chk("jr_mis_exc", 32'(exc), 32'd1);
    chk("jr_mis_red", 32'(redirect), 32'd1);
    imem_ready = 1'b0;
    tick("jr_idle");
    chk("jr_exc_clr", 32'(exc), 32'd0);
    go_to(32'h200);
    chk("jr_ok_pc", pc, 32'h200);
    chk("jr_ok_exc", 32'(exc), 32'd0);

    go_to(32'h1C);
    tick("to20");
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; jump = 1'b1; jump_addr = 26'h3FF;
      tick("stall");
      chk("stall_pc", pc, 32'h20);
    end
    clr();
    tick("stall_rel");
    chk("stall_rel_pc", pc, 32'h24);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      tick("nrdy");
      chk("nrdy_pc", pc, 32'h24);
    end
    clr();
    tick("nrdy_rel");
    chk("nrdy_rel_pc", pc, 32'h28);

    go_to(32'h40);
    halt = 1'b1;
    tick("halt");
    chk("halt_pc", pc, 32'h44);
    chk("halt_st", 32'(state), 32'd2);
    chk("halt_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 10; i++) begin
      clr();
      stall = 1'($urandom_range(1)); jr = 1'($urandom_range(1));
      jr_target = $urandom; jump = 1'($urandom_range(1));
      halt = 1'($urandom_range(1));
      tick("halt_idle");
      chk("halt_hold", pc, 32'h44);
    end
    clr(); resume = 1'b1;
    tick("resume");
    chk("resume_st", 32'(state), 32'd1);
    clr(); halt = 1'b1;
    tick("halt2");
    clr(); rst = 1'b1;
    tick("halt_rst");
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_st", 32'(state), 32'd0);
    clr();
    for (int i = 0; i < BC; i++) tick("boot2");

    go_to(32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick("wrap");
    chk("wrap_pc", pc, 32'h0);

    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(59) == 0);
      stall        = ($urandom_range(3) == 0);
      imem_ready   = ($urandom_range(3) != 0);
      jr           = ($urandom_range(7) == 0);
      jr_target    = $urandom;
      if ($urandom_range(1) == 0) jr_target[1:0] = 2'b00;
      jump         = ($urandom_range(7) == 0);
      jump_addr    = 26'($urandom);
      branch_taken = ($urandom_range(3) == 0);
      branch_off   = 16'($urandom);
      halt         = ($urandom_range(15) == 0);
      resume       = ($urandom_range(3) == 0);
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
